// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: LFSR constants and obstacle kinds.
package dino_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    OBS_NONE,
    OBS_GROUND,
    OBS_AIR
  } obstacle_t;

endpackage

// File: rtl/dino_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances once per cycle with step high.
module dino_lfsr
  import dino_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/obstacle_field.sv
// Two-row obstacle scroller: prescaled shifts, LFSR-driven spawns with a
// minimum gap between obstacles.
module obstacle_field
  import dino_pkg::*;
#(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       MIN_GAP = 2,
  parameter int unsigned       SPEED_W = 4,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  input  logic [3:0]         density,
  output logic [WIDTH-1:0]   ground,
  output logic [WIDTH-1:0]   air,
  output logic               shift_pulse,
  output logic               spawned
);

  localparam int unsigned GAP_W = 4;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP);

  logic [SPEED_W-1:0] tick_q, tick_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   ground_q, ground_d;
  logic [WIDTH-1:0]   air_q, air_d;
  logic               shift_q, shift_d;
  logic               spawned_q, spawned_d;
  logic               step_c;
  logic [LFSR_W-1:0]  lfsr_c;
  obstacle_t          obs_c;
  logic               lfsr_unused;

  dino_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step_c),
    .value (lfsr_c)
  );

  // Only the low five LFSR bits steer spawning; the rest feed the sequence.
  assign lfsr_unused = ^lfsr_c[LFSR_W-1:5];

  always_comb begin
    tick_d    = tick_q;
    gap_d     = gap_q;
    ground_d  = ground_q;
    air_d     = air_q;
    shift_d   = 1'b0;
    spawned_d = 1'b0;
    step_c    = 1'b0;
    obs_c     = OBS_NONE;
    if (clear) begin
      tick_d   = '0;
      gap_d    = GAP_RELOAD;
      ground_d = '0;
      air_d    = '0;
    end else if (en) begin
      // >= so a speed reduced below the running count fires immediately
      if (tick_q >= speed) begin
        tick_d  = '0;
        shift_d = 1'b1;
        step_c  = 1'b1;
        if ((gap_q == '0) && (lfsr_c[3:0] < density)) begin
          obs_c     = lfsr_c[4] ? OBS_AIR : OBS_GROUND;
          spawned_d = 1'b1;
          gap_d     = GAP_RELOAD;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end
        ground_d = {ground_q[WIDTH-2:0], obs_c == OBS_GROUND};
        air_d    = {air_q[WIDTH-2:0], obs_c == OBS_AIR};
      end else begin
        tick_d = tick_q + SPEED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= '0;
      gap_q     <= GAP_RELOAD;
      ground_q  <= '0;
      air_q     <= '0;
      shift_q   <= 1'b0;
      spawned_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      gap_q     <= gap_d;
      ground_q  <= ground_d;
      air_q     <= air_d;
      shift_q   <= shift_d;
      spawned_q <= spawned_d;
    end
  end

  assign ground      = ground_q;
  assign air         = air_q;
  assign shift_pulse = shift_q;
  assign spawned     = spawned_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field with a small behavioural reference of the
// scroller and its LFSR sequence.
module tb_obstacle_field;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned MIN_GAP = 2;
  localparam int unsigned SPEED_W = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               clear;
  logic [SPEED_W-1:0] speed;
  logic [3:0]         density;
  logic [WIDTH-1:0]   ground;
  logic [WIDTH-1:0]   air;
  logic               shift_pulse;
  logic               spawned;

  int errors = 0;
  int checks = 0;

  logic [15:0]      m_lfsr;
  int               m_gap;
  int               m_tick;
  logic [WIDTH-1:0] m_ground;
  logic [WIDTH-1:0] m_air;
  logic             m_shift;
  logic             m_spawn;

  obstacle_field #(
    .WIDTH   (WIDTH),
    .MIN_GAP (MIN_GAP),
    .SPEED_W (SPEED_W),
    .SEED    (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clear       (clear),
    .speed       (speed),
    .density     (density),
    .ground      (ground),
    .air         (air),
    .shift_pulse (shift_pulse),
    .spawned     (spawned)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lfsr   = SEED;
    m_gap    = MIN_GAP;
    m_tick   = 0;
    m_ground = '0;
    m_air    = '0;
    m_shift  = 1'b0;
    m_spawn  = 1'b0;
  endtask

  // Reference behaviour for one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit sp;
    bit is_air;
    m_shift = 1'b0;
    m_spawn = 1'b0;
    if (clear) begin
      m_ground = '0;
      m_air    = '0;
      m_tick   = 0;
      m_gap    = MIN_GAP;
    end else if (en) begin
      if (m_tick >= int'(speed)) begin
        m_tick   = 0;
        m_shift  = 1'b1;
        sp       = (m_gap == 0) && (int'(m_lfsr[3:0]) < int'(density));
        is_air   = m_lfsr[4];
        m_ground = {m_ground[WIDTH-2:0], 1'(sp && !is_air)};
        m_air    = {m_air[WIDTH-2:0], 1'(sp && is_air)};
        m_spawn  = sp;
        if (sp) m_gap = MIN_GAP;
        else if (m_gap > 0) m_gap = m_gap - 1;
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else m_lfsr = m_lfsr >> 1;
      end else begin
        m_tick = m_tick + 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; speed = '0; density = '0;
    #12;
    model_reset();
    checks++;
    if ({ground, air, shift_pulse, spawned} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got g=%h a=%h sp=%b sw=%b want all 0", ground, air, shift_pulse, spawned);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if ({ground, air, shift_pulse, spawned} !== '0) begin
        errors++;
        $display("FAIL idle_hold cyc %0d: got g=%h a=%h sp=%b sw=%b want all 0", i, ground, air, shift_pulse, spawned);
      end
    end
  endtask

  task automatic test_prescaler();
    en = 1'b1; speed = 4'd3; density = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      checks++;
      if (shift_pulse !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL prescale_pulse cyc %0d: got %b want %b", k, shift_pulse, (k % 4) == 0);
      end
      checks++;
      if ({ground, air, spawned} !== '0) begin
        errors++;
        $display("FAIL prescale_empty cyc %0d: got g=%h a=%h sw=%b want 0", k, ground, air, spawned);
      end
    end
  endtask

  task automatic test_spawn_model();
    int since;
    since = MIN_GAP;
    speed = 4'd0; density = 4'd15;
    for (int i = 0; i < 200; i++) begin
      en = !((i % 37) >= 30 && (i % 37) <= 33);
      cyc();
      checks++;
      if ({ground, air, shift_pulse, spawned} !== {m_ground, m_air, m_shift, m_spawn}) begin
        errors++;
        $display("FAIL spawn_model cyc %0d: got g=%h a=%h sp=%b sw=%b want g=%h a=%h sp=%b sw=%b",
                 i, ground, air, shift_pulse, spawned, m_ground, m_air, m_shift, m_spawn);
      end
      checks++;
      if ((ground & air) !== '0) begin
        errors++;
        $display("FAIL both_rows cyc %0d: got overlap %h want 0", i, ground & air);
      end
      if (shift_pulse === 1'b1) begin
        if (spawned === 1'b1) begin
          checks++;
          if (since < MIN_GAP) begin
            errors++;
            $display("FAIL spawn_gap cyc %0d: got %0d empty shifts want >= %0d", i, since, MIN_GAP);
          end
          since = 0;
        end else begin
          since++;
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_travel();
    bit is_air;
    bit found;
    logic [WIDTH-1:0] exp_row;
    logic [WIDTH-1:0] row;
    logic [WIDTH-1:0] other;
    clear = 1'b1; en = 1'b1; speed = 4'd0; density = 4'd15;
    cyc();
    clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (spawned === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL travel_spawn_timeout: got no spawn want spawn within 40 cycles");
    end
    is_air = air[0];
    density = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      exp_row = (k < 16) ? (WIDTH'(1) << k) : '0;
      row     = is_air ? air : ground;
      other   = is_air ? ground : air;
      checks++;
      if (row !== exp_row || other !== '0) begin
        errors++;
        $display("FAIL travel shift %0d: got row=%h other=%h want row=%h other=0", k, row, other, exp_row);
      end
    end
  endtask

  task automatic test_clear();
    en = 1'b1; speed = 4'd0; density = 4'd15;
    for (int i = 0; i < 10; i++) cyc();
    clear = 1'b1;
    cyc();
    checks++;
    if ({ground, air, shift_pulse, spawned} !== '0) begin
      errors++;
      $display("FAIL clear_outputs: got g=%h a=%h sp=%b sw=%b want all 0", ground, air, shift_pulse, spawned);
    end
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (shift_pulse !== 1'b1 || spawned !== 1'b0) begin
        errors++;
        $display("FAIL clear_gap shift %0d: got sp=%b sw=%b want sp=1 sw=0", i, shift_pulse, spawned);
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if ({ground, air, spawned} !== {m_ground, m_air, m_spawn}) begin
        errors++;
        $display("FAIL clear_resume cyc %0d: got g=%h a=%h sw=%b want g=%h a=%h sw=%b",
                 i, ground, air, spawned, m_ground, m_air, m_spawn);
      end
    end
  endtask

  task automatic test_speed_change();
    logic exp_pulse [5];
    exp_pulse = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear = 1'b1; en = 1'b1; density = 4'd0; speed = 4'd7;
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (shift_pulse !== 1'b0) begin
        errors++;
        $display("FAIL slow_count cyc %0d: got %b want 0", i, shift_pulse);
      end
    end
    speed = 4'd1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (shift_pulse !== exp_pulse[i]) begin
        errors++;
        $display("FAIL speed_drop cyc %0d: got %b want %b", i, shift_pulse, exp_pulse[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit busy;
    en = 1'b1; speed = 4'd0; density = 4'd15;
    busy = 1'b0;
    for (int i = 0; i < 40 && !busy; i++) begin
      cyc();
      if ((ground | air) !== '0) busy = 1'b1;
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL async_setup: got empty rows want an obstacle within 40 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ground, air, shift_pulse, spawned} !== '0) begin
      errors++;
      $display("FAIL async_reset: got g=%h a=%h sp=%b sw=%b want all 0", ground, air, shift_pulse, spawned);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if ({ground, air, shift_pulse, spawned} !== {m_ground, m_air, m_shift, m_spawn}) begin
        errors++;
        $display("FAIL post_reset_seq cyc %0d: got g=%h a=%h sp=%b sw=%b want g=%h a=%h sp=%b sw=%b",
                 i, ground, air, shift_pulse, spawned, m_ground, m_air, m_shift, m_spawn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_spawn_model();
    test_travel();
    test_clear();
    test_speed_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
